tx_arb_ctrl: RTL
================

Name: tx_arb_ctrl

Overview:
Round-robin arbiter and sequencer that shares one serial TX link between NUM_REQ byte sources. It grants one requester and, once the receiver signals rx_ready, loads that requester's parallel word into an internal shift register. It then shifts the word out LSB-first with tx_vld and acknowledges the requester. It sits between the memory/word sources and the serial link toward the RX side.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
DATA_W, 8, bits per word
SRC_W, $clog2(NUM_REQ), width of tx_src (localparam, min 1)

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  asynchronous, active-high reset
rx_ready  in  1  receiver can accept a word
req  in  NUM_REQ  per-requester request; held until matching ack
data  in  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]; stable while req[i]=1
ack  out  NUM_REQ  one-cycle pulse: word of requester i fully sent
tx_bit  out  1  serial data, LSB first
tx_vld  out  1  tx_bit is valid this cycle
tx_src  out  SRC_W  index of granted requester; valid while busy=1
busy  out  1  high in LOAD, SHIFT and DONE states

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; shift register and bit counter = 0; last_grant = NUM_REQ-1, so requester 0 wins first.
  - All outputs 0, including ack, tx_vld, tx_bit, tx_src and busy.
  - Reset mid-transfer aborts the word: no ack, no further bits.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Outputs 0.
  - If rx_ready=1 and |req, then at the clock edge: grant = first set req scanning last_grant+1 upward with wrap modulo NUM_REQ; tx_src <= grant; next state LOAD.
  - Otherwise stay in IDLE.
- LOAD: busy=1, tx_vld=0. At the edge: shift_reg <= data[grant], counter <= 0, next state SHIFT.
- SHIFT:
  - tx_vld=1, tx_bit=shift_reg[0].
  - Each edge: shift right (zero fill), counter++.
  - When counter==DATA_W-1 at the edge, next state DONE.
  - tx_vld is high for exactly DATA_W consecutive cycles.
- DONE: ack[grant]=1 for one cycle, tx_vld=0; last_grant <= grant; next state IDLE.
- Latency: request sampled at edge k; bit0 is valid in the cycle after edge k+1; ack is in the cycle after the last bit.
- Minimum gap between words is 3 cycles with tx_vld=0 (DONE, IDLE, LOAD).
- rx_ready is sampled only in IDLE unless TX_PAUSE_EN is defined.
- req changes after grant are ignored. The word completes and ack is still issued even if req dropped (protocol violation, not checked).
- New requests arriving during a transfer wait. Round-robin guarantees each persistent requester is served within NUM_REQ words.
- ack is one-hot or zero. ack and tx_vld are never high in the same cycle.

Optional Feature:
Macro TX_PAUSE_EN.
- Defined: in SHIFT with rx_ready=0, tx_vld=0, shift register and counter hold. Transmission resumes with the same bit when rx_ready returns. Word length in cycles = DATA_W + stall cycles.
- Undefined: rx_ready is ignored outside IDLE; SHIFT always runs DATA_W cycles.

Decomposition:
- Shared package/header tx_pkg holds:
  - FSM state encodings for IDLE, LOAD, SHIFT, DONE;
  - default DATA_W;
  - a clog2 helper/constant for SRC_W.
- One natural sub-module, tx_shift_reg: parallel load, right shift with enable, LSB output, async active-high clear. Reusable by the existing TX path.
- The arbiter's next-grant search stays in tx_arb_ctrl.

Test Plan:
1. Reset release; req=2'b01, data0=8'hA5, rx_ready=1 -> tx_src=0; tx_bit 1,0,1,0,0,1,0,1 over 8 tx_vld cycles; bit0 one cycle after LOAD; ack=2'b01 for one cycle next.
2. req=2'b11 held, data0=8'h0F, data1=8'hF0, rx_ready=1 -> grants 0,1,0,1; acks alternate; 3 idle cycles between words.
3. req=2'b01, rx_ready=0 for 10 cycles -> busy=0, tx_vld=0 throughout; raise rx_ready -> LOAD next cycle, normal word follows.
4. clr pulse during bit 3 of data0=8'hA5 -> all outputs 0 immediately, no ack; after release with req0 still high -> full word restarts from bit0, tx_src=0.
5. With TX_PAUSE_EN: rx_ready=0 for 3 cycles while bit 3 is presented -> tx_vld low 3 cycles, bit 3 re-presented, total 11 cycles to ack. Without the macro: 8 uninterrupted cycles.
6. Only req1 active, req0 raised mid-transfer -> word 1 completes with ack[1], then requester 0 granted next.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the serial TX arbiter path.
package tx_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, right-shift register with LSB serial output.
module tx_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)          sr_d = din;
    else if (shift_en) sr_d = {1'b0, sr_q[W-1:1]};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign sout = sr_q[0];

endmodule

// File: rtl/tx_arb_ctrl.sv
// Round-robin arbiter feeding one LSB-first serial TX link.
// Optional TX_PAUSE_EN: rx_ready low during SHIFT stalls the bit stream.
//   state | meaning
//   IDLE  | wait for rx_ready and any request, pick next grant
//   LOAD  | copy granted word into shift register
//   SHIFT | present one bit per cycle with tx_vld
//   DONE  | one-cycle ack to granted requester
module tx_arb_ctrl
  import tx_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int SRC_W   = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      rx_ready,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_bit,
  output logic                      tx_vld,
  output logic [SRC_W-1:0]          tx_src,
  output logic                      busy
);

  localparam int CNT_W = clog2_min1(DATA_W);

  tx_state_e        state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] grant_nxt;
  logic             sr_load, sr_shift, sr_bit, adv;

  // First set request strictly after last_grant, wrapping.
  always_comb begin
    int idx;
    logic found;
    grant_nxt = last_grant_q;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant_nxt = SRC_W'(idx);
        found     = 1'b1;
      end
    end
  end

`ifdef TX_PAUSE_EN
  assign adv = rx_ready;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    busy         = 1'b0;
    tx_vld       = 1'b0;
    tx_bit       = 1'b0;
    ack          = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready && |req) begin
          grant_d = grant_nxt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy    = 1'b1;
        sr_load = 1'b1;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (adv) begin
          tx_vld   = 1'b1;
          tx_bit   = sr_bit;
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        ack[grant_q] = 1'b1;
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_src = busy ? grant_q : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  tx_shift_reg #(.W(DATA_W)) u_shift (
    .clk      (clk),
    .clr      (clr),
    .load     (sr_load),
    .shift_en (sr_shift),
    .din      (data[grant_q*DATA_W +: DATA_W]),
    .sout     (sr_bit)
  );

endmodule
